instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Parametrised prefetching instruction fetch unit. It replaces the single-entry instruction buffer and the fetch half of the control FSM in the next-generation core. It runs the instr_req/instr_valid handshake toward instruction memory autonomously and queues fetched words with their PCs in a DEPTH-entry FIFO. It supports a redirect (branch/jump) that flushes the queue and discards any in-flight response.

Parameters:
XLEN, 32, width of PC and instruction word
DEPTH, 4, FIFO entries; power of two, at least 2
RESET_PC, 32'h0000_0000, fetch address after reset; must be 4-byte aligned

Ports:
CLK  input  1  clock, rising edge
RES  input  1  reset, asynchronous, active-low
instr_req  output  1  memory request; held high until instr_valid
instr_adr  output  XLEN  fetch address; stable while instr_req is high
instr_valid  input  1  one-cycle response strobe; instr_read is valid in that cycle
instr_read  input  XLEN  fetched instruction word
fetch_valid  output  1  FIFO head valid
fetch_instr  output  XLEN  head instruction
fetch_pc  output  XLEN  PC of head instruction
fetch_ready  input  1  core consumes head when fetch_valid is also high
redirect  input  1  flush the queue and restart fetch at redirect_pc
redirect_pc  input  XLEN  new fetch address; bits [1:0] ignored and forced to 0

Behaviour:
- Reset (RES low, asynchronous):
  - state = IDLE, fpc = RESET_PC, FIFO count/read pointer/write pointer = 0.
  - instr_req = 0, fetch_valid = 0, fetch_instr = 0, fetch_pc = 0.
  - Reset mid-request abandons the request. Memory is reset by the same RES.
- State machine:
  - IDLE, REQ, DROP. instr_req = (state != IDLE). instr_adr = fpc in REQ, latched old address in DROP.
  - At most one request is outstanding.
- IDLE -> REQ when the FIFO is not full, or when redirect is high (the FIFO is flushed, so it is not full). The first request is asserted in the cycle after reset release.
- REQ with instr_valid and no redirect:
  - Push {fpc, instr_read}; fpc += 4 (wraps modulo 2^XLEN).
  - Stay in REQ if count_next < DEPTH, where count_next includes the same-cycle pop; otherwise go to IDLE.
- REQ with redirect and no instr_valid:
  - Flush FIFO; fpc = redirect_pc & ~3; latch the old address.
  - Go to DROP; instr_req stays high with the old address.
- REQ with redirect and instr_valid in the same cycle: the response is discarded, the FIFO is flushed, fpc = redirect_pc & ~3, and the state stays REQ with the new address next cycle.
- DROP:
  - On instr_valid, discard the data and go to REQ with fpc.
  - A further redirect in DROP updates fpc only (last redirect wins).
- Output side:
  - fetch_valid = (count != 0); fetch_instr/fetch_pc come from the head entry, combinationally from registered storage.
  - A pop occurs when fetch_valid & fetch_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH; count width is clog2(DEPTH+1).
- Redirect priority: redirect beats push and pop in the same cycle. The FIFO is empty next cycle and fetch_valid = 0.
- Full: no new request is issued while count == DEPTH. A response can never arrive when the FIFO is full, because only one request is outstanding and issue checks space.
- Empty with fetch_ready high: no pop, no pointer change.
- Latency: with the queue empty and 1-cycle memory, instr_valid in cycle N gives fetch_valid in cycle N+1.
- Throughput: one word per memory response with no bubble while space remains.

Decomposition:
- Shared package ifu_pkg holds:
  - state encoding constants IFU_IDLE = 2'd0, IFU_REQ = 2'd1, IFU_DROP = 2'd2;
  - INSTR_BYTES = 4;
  - the alignment mask.
- Sub-module fetch_fifo: synchronous FIFO (DEPTH, width 2*XLEN) with push, pop, flush, count, full and empty.
- instr_fetch_unit holds the FSM, fpc and the handshake, and instantiates fetch_fifo.

Test Plan:
- Reset, then 1-cycle memory, fetch_ready = 1 -> instr_adr = 0, 4, 8, 12 on successive responses; fetch_pc follows 0, 4, 8, … with the matching instr_read words; no bubbles.
- fetch_ready = 0, DEPTH = 4 -> exactly 4 responses accepted, then instr_req = 0 with count = 4. Raise fetch_ready for 1 cycle -> pop PC 0, then a request for 0x10 is issued.
- Redirect to 0x103 while a request for 0x8 is outstanding (memory latency 3) -> DROP state; the 0x8 response is discarded; the next instr_adr is 0x100; the first fetch_pc after the redirect is 0x100.
- Redirect coincident with instr_valid and with a pop -> the response is discarded, the FIFO is empty next cycle (fetch_valid = 0), and instr_adr = redirect_pc next cycle.
- Wrap: redirect_pc = 0xFFFF_FFFC -> next fetch addresses 0xFFFF_FFFC, then 0x0000_0000.
- Assert RES low mid-request with 3 entries queued -> outputs 0 immediately (asynchronously); after release, the first instr_adr = RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - FSM state encoding (IFU_IDLE / IFU_REQ / IFU_DROP) and the state enum
//   - INSTR_BYTES: PC increment per fetched word
//   - ALIGN_MASK: low PC bits cleared on redirect
package ifu_pkg;

  localparam logic [1:0] IFU_IDLE = 2'd0;
  localparam logic [1:0] IFU_REQ  = 2'd1;
  localparam logic [1:0] IFU_DROP = 2'd2;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned ALIGN_MASK  = INSTR_BYTES - 1;

  typedef enum logic [1:0] {
    S_IDLE = IFU_IDLE,
    S_REQ  = IFU_REQ,
    S_DROP = IFU_DROP
  } ifu_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the fetch unit.
//   memory side : instr_req, instr_adr (out) / instr_valid, instr_read (in)
//   core side   : fetch_valid, fetch_instr, fetch_pc (out) /
//                 fetch_ready, redirect, redirect_pc (in)
// master = fetch unit, slave = memory + core environment.
interface instr_fetch_unit_if #(parameter int XLEN = 32);
  logic            instr_req;
  logic [XLEN-1:0] instr_adr;
  logic            instr_valid;
  logic [XLEN-1:0] instr_read;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_instr;
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output instr_req, instr_adr, fetch_valid, fetch_instr, fetch_pc,
    input  instr_valid, instr_read, fetch_ready, redirect, redirect_pc
  );

  modport slave (
    input  instr_req, instr_adr, fetch_valid, fetch_instr, fetch_pc,
    output instr_valid, instr_read, fetch_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: synchronous DEPTH-entry FIFO holding {pc, instr} pairs.
//   gclk/grst_n : clock, async active-low reset
//   push/wdata  : write (ignored when full)
//   pop/rdata   : read head (ignored when empty); rdata reads 0 when empty
//   flush       : empties the FIFO, beats push and pop
//   count/full/empty : occupancy
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           rptr, wptr;
  logic                    do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge gclk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Gate the head so stale storage never shows on the outputs.
  assign rdata = empty ? '0 : mem[rptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: prefetching fetch unit. Issues one outstanding memory
// request at a time while the queue has room, queues {pc, instr} words, and
// flushes on redirect, dropping any response still in flight.
//   CLK, RES : clock, async active-low reset
//   bus      : instr_fetch_unit_if.master (memory + core handshakes)
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   CLK,
  input  logic                   RES,
  instr_fetch_unit_if.master     bus
);
  localparam int CW = $clog2(DEPTH + 1);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] old_adr_q, old_adr_d;
  logic [XLEN-1:0] new_pc;
  logic [CW-1:0]   count;
  logic            full, empty, push, pop, room_after;
  logic [2*XLEN-1:0] rdata;

  assign new_pc     = bus.redirect_pc & ~XLEN'(ALIGN_MASK);
  assign pop        = bus.fetch_valid & bus.fetch_ready;
  // Occupancy after this cycle's push and any same-cycle pop.
  assign room_after = (int'(count) + 1 - int'(pop)) < DEPTH;

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q   <= S_IDLE;
      fpc_q     <= RESET_PC;
      old_adr_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      old_adr_q <= old_adr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    old_adr_d = old_adr_q;
    push      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.redirect) begin
          fpc_d   = new_pc;
          state_d = S_REQ;
        end else if (!full) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.redirect) begin
          fpc_d = new_pc;
          // Request still open: keep presenting its address until it lands.
          if (!bus.instr_valid) begin
            old_adr_d = fpc_q;
            state_d   = S_DROP;
          end
        end else if (bus.instr_valid) begin
          push  = 1'b1;
          fpc_d = fpc_q + XLEN'(INSTR_BYTES);
          if (!room_after) state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (bus.redirect)    fpc_d   = new_pc;
        if (bus.instr_valid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.instr_req = (state_q != S_IDLE);
  assign bus.instr_adr = (state_q == S_DROP) ? old_adr_q : fpc_q;

  fetch_fifo #(.DEPTH(DEPTH), .W(2*XLEN)) u_fifo (
    .gclk   (CLK),
    .grst_n (RES),
    .push   (push),
    .wdata  ({fpc_q, bus.instr_read}),
    .pop    (pop),
    .rdata  (rdata),
    .flush  (bus.redirect),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign bus.fetch_valid = ~empty;
  assign bus.fetch_pc    = rdata[2*XLEN-1:XLEN];
  assign bus.fetch_instr = rdata[XLEN-1:0];
endmodule
